// File: rtl/accumulator_sequencer_pkg.sv
// Shared constants for the accumulator beat sequencer: beat encodings, opcodes,
// beat length and the sequencer state encoding.
package accumulator_sequencer_pkg;

  localparam int INSTR_BITS_DEF   = 20;
  localparam int FLYBACK_TIME_DEF = 4;
  localparam int BEAT_LEN         = INSTR_BITS_DEF + FLYBACK_TIME_DEF;

  localparam int ADDR_BITS = 5;
  localparam int FUNC_BITS = 3;
  localparam int FUNC_LSB  = 13;

  typedef enum logic [1:0] {
    BEAT_S1 = 2'd0,
    BEAT_A1 = 2'd1,
    BEAT_S2 = 2'd2,
    BEAT_A2 = 2'd3
  } beat_e;

  typedef enum logic [2:0] {
    FUNC_JMP     = 3'd0,
    FUNC_JRP     = 3'd1,
    FUNC_LDN     = 3'd2,
    FUNC_STO     = 3'd3,
    FUNC_SUB     = 3'd4,
    FUNC_SUB_ALT = 3'd5,
    FUNC_CMP     = 3'd6,
    FUNC_STP     = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_A1   = 3'd2,
    ST_S2   = 3'd3,
    ST_A2   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // IDLE and HALT report beat 0 so downstream logic sees a quiet S1 encoding.
  function automatic beat_e state_to_beat(input state_e s);
    case (s)
      ST_S1:   return BEAT_S1;
      ST_A1:   return BEAT_A1;
      ST_S2:   return BEAT_S2;
      ST_A2:   return BEAT_A2;
      default: return BEAT_S1;
    endcase
  endfunction

endpackage

// File: rtl/accumulator_sequencer_if.sv
// Bundle between the store/CI logic, the sequencer and the accumulator top level.
interface accumulator_sequencer_if;
  import accumulator_sequencer_pkg::*;

  // No valid/ready pairs here: every strobe is beat-timed and sampled on each
  // w_DPG posedge; b_BEAT plus w_XTB tell the consumer where in the word it is.
  logic                 w_RUN;
  logic                 w_S_DATA_IN;
  logic                 w_A_DATA_OUT;
  logic                 w_XTB;
  logic                 w_ACTION_WF;
  logic                 w_A_ZERO;
  logic                 w_INSTR_1_13;
  logic                 w_INSTR_1_14;
  logic                 w_INSTR_1_15;
  logic [ADDR_BITS-1:0] b_INSTR_ADDR;
  logic                 w_SKIP;
  logic                 w_STOPPED;
  logic [1:0]           b_BEAT;
  state_e               dbg_state;

  modport master (
    input  w_RUN, w_S_DATA_IN, w_A_DATA_OUT,
    output w_XTB, w_ACTION_WF, w_A_ZERO,
    output w_INSTR_1_13, w_INSTR_1_14, w_INSTR_1_15, b_INSTR_ADDR,
    output w_SKIP, w_STOPPED, b_BEAT, dbg_state
  );

  modport slave (
    output w_RUN, w_S_DATA_IN, w_A_DATA_OUT,
    input  w_XTB, w_ACTION_WF, w_A_ZERO,
    input  w_INSTR_1_13, w_INSTR_1_14, w_INSTR_1_15, b_INSTR_ADDR,
    input  w_SKIP, w_STOPPED, b_BEAT, dbg_state
  );

endinterface

// File: rtl/accumulator_sequencer_digit_timer.sv
// Digit counter for one beat: counts 0..BEAT_LEN-1 while enabled, flags the wrap digit.
module accumulator_sequencer_digit_timer #(
  parameter int BEAT_LEN = 24,
  parameter int DW       = $clog2(BEAT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [DW-1:0] digit,
  output logic          wrap
);

  localparam logic [DW-1:0] LAST = DW'(BEAT_LEN - 1);

  assign wrap = en && (digit == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= wrap ? '0 : digit + DW'(1);
    end
  end

endmodule

// File: rtl/accumulator_sequencer.sv
// Beat/digit sequencer: runs S1/A1/S2/A2 per instruction, captures the serial
// instruction in A1 and drives the accumulator write/zero/skip strobes in A2.
module accumulator_sequencer
  import accumulator_sequencer_pkg::*;
#(
  parameter int INSTR_BITS   = INSTR_BITS_DEF,
  parameter int FLYBACK_TIME = FLYBACK_TIME_DEF
) (
  input logic                     w_DPG,
  input logic                     w_RST,
  accumulator_sequencer_if.master bus
);

  localparam int BEAT_CYCLES = INSTR_BITS + FLYBACK_TIME;
  localparam int DW          = $clog2(BEAT_CYCLES);
  localparam logic [DW-1:0] SIGN_DIGIT = DW'(INSTR_BITS - 1);

  state_e                state_q;
  state_e                state_d;
  logic [DW-1:0]         digit;
  logic                  wrap;
  logic                  running;
  logic [ADDR_BITS-1:0]  shadow_addr;
  logic [FUNC_BITS-1:0]  shadow_func;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [FUNC_BITS-1:0]  func_q;
  logic                  action_wf_q;
  logic                  a_zero_q;
  logic                  skip_q;

  assign running = state_q inside {ST_S1, ST_A1, ST_S2, ST_A2};

  accumulator_sequencer_digit_timer #(
    .BEAT_LEN (BEAT_CYCLES),
    .DW       (DW)
  ) u_digit_timer (
    .clk   (w_DPG),
    .rst   (w_RST),
    .en    (running),
    .clr   (!running),
    .digit (digit),
    .wrap  (wrap)
  );

  always_ff @(posedge w_DPG) begin
    if (w_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // w_RUN is only looked at in IDLE, HALT and on the A2 wrap, so an
  // instruction in flight always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.w_RUN) state_d = ST_S1;
      ST_S1:   if (wrap) state_d = ST_A1;
      ST_A1:   if (wrap) state_d = ST_S2;
      ST_S2:   if (wrap) state_d = ST_A2;
      ST_A2: begin
        if (wrap) begin
          if (func_q == FUNC_STP) begin
            state_d = ST_HALT;
          end else if (!bus.w_RUN) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_S1;
          end
        end
      end
      ST_HALT: if (!bus.w_RUN) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the address and function digits are kept; the rest of the word
  // passes through A1 unused. The latched copy moves on the A1 wrap.
  always_ff @(posedge w_DPG) begin
    if (w_RST) begin
      shadow_addr <= '0;
      shadow_func <= '0;
      addr_q      <= '0;
      func_q      <= FUNC_JMP;
    end else if (state_q == ST_A1) begin
      for (int i = 0; i < ADDR_BITS; i++) begin
        if (digit == DW'(i)) shadow_addr[i] <= bus.w_S_DATA_IN;
      end
      for (int i = 0; i < FUNC_BITS; i++) begin
        if (digit == DW'(FUNC_LSB + i)) shadow_func[i] <= bus.w_S_DATA_IN;
      end
      if (wrap) begin
        addr_q <= shadow_addr;
        func_q <= shadow_func;
      end
    end
  end

  // Strobes are registered off the next state so they line up with A2 digit 0.
  always_ff @(posedge w_DPG) begin
    if (w_RST) begin
      action_wf_q <= 1'b1;
      a_zero_q    <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      action_wf_q <= (state_d != ST_A2);
      a_zero_q    <= (state_d == ST_A2) && (func_q == FUNC_LDN);
      if ((state_q == ST_A2) && (func_q == FUNC_CMP) && (digit == SIGN_DIGIT)) begin
        skip_q <= bus.w_A_DATA_OUT;
      end else if ((state_q == ST_S1) && wrap) begin
        skip_q <= 1'b0;
      end
    end
  end

  assign bus.w_XTB        = wrap;
  assign bus.w_ACTION_WF  = action_wf_q;
  assign bus.w_A_ZERO     = a_zero_q;
  assign bus.w_INSTR_1_13 = func_q[0];
  assign bus.w_INSTR_1_14 = func_q[1];
  assign bus.w_INSTR_1_15 = func_q[2];
  assign bus.b_INSTR_ADDR = addr_q;
  assign bus.w_SKIP       = skip_q && (state_q == ST_S1);
  assign bus.w_STOPPED    = (state_q == ST_HALT);
  assign bus.b_BEAT       = state_to_beat(state_q);
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer: per-cycle expected output vectors are
// queued by the driver and checked by an independent negedge monitor.
module tb_accumulator_sequencer;
  import accumulator_sequencer_pkg::*;

  localparam int W  = 15;
  localparam int BL = BEAT_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;

  accumulator_sequencer_if bus ();

  accumulator_sequencer dut (
    .w_DPG (clk),
    .w_RST (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: {xtb, action_wf, a_zero, i15, i14, i13, addr[4:0], skip, stopped, beat[1:0]}
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;

  logic [2:0] m_fn   = 3'd0;
  logic [4:0] m_ad   = 5'd0;
  logic       m_skip = 1'b0;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  int           mon_tag;

  function automatic logic [W-1:0] mk(input logic xtb, input logic awf, input logic az,
                                      input logic [2:0] fn, input logic [4:0] ad,
                                      input logic sk, input logic st, input logic [1:0] bt);
    return {xtb, awf, az, fn, ad, sk, st, bt};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {bus.w_XTB, bus.w_ACTION_WF, bus.w_A_ZERO,
                 bus.w_INSTR_1_15, bus.w_INSTR_1_14, bus.w_INSTR_1_13,
                 bus.b_INSTR_ADDR, bus.w_SKIP, bus.w_STOPPED, bus.b_BEAT};
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL outvec cycle=%0d actual=%b required=%b", mon_tag, mon_act, mon_exp);
      end
    end
  end

  task automatic step(input logic [W-1:0] e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(cyc);
    cyc++;
  endtask

  task automatic drive_noise();
    bus.w_S_DATA_IN  = 1'($urandom_range(0, 1));
    bus.w_A_DATA_OUT = 1'($urandom_range(0, 1));
  endtask

  // Quiet cycles in IDLE or HALT; run_val is the w_RUN level presented each cycle.
  task automatic idle_steps(input int n, input logic run_val, input logic halted);
    for (int i = 0; i < n; i++) begin
      step(mk(1'b0, 1'b1, 1'b0, m_fn, m_ad, 1'b0, halted, 2'd0));
      bus.w_RUN = run_val;
      drive_noise();
    end
  endtask

  // One full instruction starting with the first S1 cycle on the next edge.
  // fn/ad are the hand-decoded fields of word; rst_at < 0 means no reset.
  task automatic do_instr(input logic [19:0] word, input logic [2:0] fn, input logic [4:0] ad,
                          input logic a_sign, input logic run_during, input int rst_at);
    for (int c = 0; c < 4 * BL; c++) begin
      int b;
      int d;
      b = c / BL;
      d = c % BL;
      if (c == 2 * BL) begin
        m_fn = fn;
        m_ad = ad;
      end
      step(mk(d == BL - 1, b != 3, (b == 3) && (m_fn == 3'd2), m_fn, m_ad,
              (b == 0) && m_skip, 1'b0, 2'(b)));
      if (c == BL - 1) m_skip = 1'b0;
      if (c == 3 * BL + 19 && fn == 3'd6) m_skip = a_sign;
      drive_noise();
      if (c >= BL && c < BL + 20) bus.w_S_DATA_IN = word[c - BL];
      if (c == 3 * BL + 19) bus.w_A_DATA_OUT = a_sign;
      if (c == BL) bus.w_RUN = run_during;
      if (c == rst_at) begin
        rst = 1'b1;
        m_fn   = 3'd0;
        m_ad   = 5'd0;
        m_skip = 1'b0;
        step(mk(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 2'd0));
        rst = 1'b0;
        bus.w_RUN = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bus.w_RUN = 1'b0;
    drive_noise();
    rst = 1'b1;
    idle_steps(3, 1'b0, 1'b0);
    rst = 1'b0;
    idle_steps(2, 1'b0, 1'b0);
    idle_steps(1, 1'b1, 1'b0);

    do_instr(20'h24105, 3'd2, 5'd5,  1'b0, 1'b1, -1);  // LDN line 5, extra word bits set
    do_instr(20'h0C003, 3'd6, 5'd3,  1'b1, 1'b1, -1);  // CMP, accumulator negative
    do_instr(20'h02011, 3'd1, 5'd17, 1'b1, 1'b1, -1);  // JRP: skip visible in its S1
    do_instr(20'h0C01F, 3'd6, 5'd31, 1'b0, 1'b1, -1);  // CMP, accumulator positive
    do_instr(20'h08002, 3'd4, 5'd2,  1'b1, 1'b0, -1);  // SUB, w_RUN dropped in A1
    idle_steps(5, 1'b0, 1'b0);
    idle_steps(1, 1'b1, 1'b0);

    do_instr(20'h46009, 3'd3, 5'd9,  1'b0, 1'b1, -1);  // STO
    do_instr(20'h0E000, 3'd7, 5'd0,  1'b1, 1'b1, -1);  // STP
    idle_steps(30, 1'b1, 1'b1);
    idle_steps(1, 1'b0, 1'b1);
    idle_steps(1, 1'b1, 1'b0);

    do_instr(20'h0A004, 3'd5, 5'd4,  1'b0, 1'b1, 3 * BL + 10);  // reset at A2 digit 10
    idle_steps(3, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
